// File: rtl/led_event_flasher.sv
`default_nettype none
// ============================================================================
//  Module      : led_event_flasher
//  Description : Stretches single-cycle event strobes into visible LED blinks.
//                Strobes arriving mid-blink are queued in a saturating counter
//                and replayed as back-to-back blinks.
//  Revision    : 1.0  initial release
// ============================================================================
module led_event_flasher #(
    parameter int ON_CNT  = 12500000,
    parameter int GAP_CNT = 12500000,
    parameter int PEND_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pulse,
    output logic              o_led,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_drop
);

    localparam int c_MAX_CNT = (ON_CNT > GAP_CNT) ? ON_CNT : GAP_CNT;
    localparam int c_TMR_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_TMR_W-1:0] c_ON_LOAD  = c_TMR_W'(ON_CNT - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LOAD = c_TMR_W'(GAP_CNT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [PEND_W-1:0]  c_PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0]  c_PEND_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_TMR_W-1:0]  w_timer_nxt;
    logic [PEND_W-1:0]   r_pending;
    logic [PEND_W-1:0]   w_pending_nxt;
    logic                r_led;
    logic                r_busy;
    logic                r_drop;

    logic                w_inc;
    logic                w_gap_done;
    logic                w_dec;
    logic                w_drop;

    // Queue bookkeeping: a strobe while busy enqueues; the end of a gap
    // dequeues if anything (including this cycle's strobe) is waiting.
    always_comb begin
        w_inc      = i_pulse && (r_state != ST_IDLE);
        w_gap_done = (r_state == ST_GAP) && (r_timer == '0);
        w_dec      = w_gap_done && ((r_pending != '0) || w_inc);
        // A dequeue in the same cycle frees a slot, so no event is lost then.
        w_drop     = w_inc && !w_dec && (r_pending == c_PEND_MAX);

        w_pending_nxt = r_pending;
        if (w_inc && !w_dec && (r_pending != c_PEND_MAX)) begin
            w_pending_nxt = r_pending + c_PEND_ONE;
        end else if (w_dec && !w_inc) begin
            w_pending_nxt = r_pending - c_PEND_ONE;
        end
    end

    // Next-state and timer: ON and GAP each run a down-count to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (i_pulse) begin
                    w_state_nxt = ST_ON;
                    w_timer_nxt = c_ON_LOAD;
                end
            end
            ST_ON: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = c_GAP_LOAD;
                end else begin
                    w_timer_nxt = r_timer - c_TMR_ONE;
                end
            end
            ST_GAP: begin
                if (r_timer == '0) begin
                    if (w_dec) begin
                        w_state_nxt = ST_ON;
                        w_timer_nxt = c_ON_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - c_TMR_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_pending <= '0;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= w_pending_nxt;
            r_led     <= (w_state_nxt == ST_ON);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_drop    <= w_drop;
        end
    end

    assign o_led     = r_led;
    assign o_busy    = r_busy;
    assign o_pending = r_pending;
    assign o_drop    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_led_event_flasher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_event_flasher
//  Description : Directed bench for led_event_flasher with a blink-position
//                reference model and literal trace expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_event_flasher;

    localparam int c_ON   = 4;
    localparam int c_GAP  = 2;
    localparam int c_PW   = 2;
    localparam int c_PMAX = (1 << c_PW) - 1;

    logic            clk;
    logic            rst_n;
    logic            i_pulse;
    logic            o_led;
    logic            o_busy;
    logic [c_PW-1:0] o_pending;
    logic            o_drop;

    int n_checks;
    int n_pass;
    bit cmp_en;

    led_event_flasher #(
        .ON_CNT  (c_ON),
        .GAP_CNT (c_GAP),
        .PEND_W  (c_PW)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_pulse   (i_pulse),
        .o_led     (o_led),
        .o_busy    (o_busy),
        .o_pending (o_pending),
        .o_drop    (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a blink is a window of ON+GAP cycles indexed by m_pos;
    // owed blinks are a plain integer that clips at the queue capacity.
    bit m_active;
    int m_pos;
    int m_pend;
    bit m_drop;

    always @(posedge clk or negedge rst_n) begin
        int total;
        if (!rst_n) begin
            m_active = 0; m_pos = 0; m_pend = 0; m_drop = 0;
        end else begin
            m_drop = 0;
            if (!m_active) begin
                if (i_pulse) begin m_active = 1; m_pos = 0; end
            end else begin
                total = m_pend + (i_pulse ? 1 : 0);
                if (m_pos == c_ON + c_GAP - 1) begin
                    if (total > 0) begin m_pos = 0; total = total - 1; end
                    else m_active = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
                if (total > c_PMAX) begin m_drop = 1; total = c_PMAX; end
                m_pend = total;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_led",  64'(o_led),     64'(m_active && (m_pos < c_ON)));
            check("model_busy", 64'(o_busy),    64'(m_active));
            check("model_pend", 64'(o_pending), 64'(m_pend));
            check("model_drop", 64'(o_drop),    64'(m_drop));
        end
    end

    // Traces indexed by cycle number: bit c = value after edge c-1.
    logic [63:0]     led_tr;
    logic [63:0]     busy_tr;
    logic [63:0]     drop_tr;
    logic [c_PW-1:0] pend_tr [0:63];
    logic [c_PW-1:0] pend_or;

    task automatic run(input logic [63:0] mask, input int ncyc);
        led_tr = '0; busy_tr = '0; drop_tr = '0; pend_or = '0;
        for (int i = 0; i < 64; i++) pend_tr[i] = '0;
        for (int c = 0; c < ncyc; c++) begin
            i_pulse = mask[c];
            @(negedge clk);
            led_tr[c+1]  = o_led;
            busy_tr[c+1] = o_busy;
            drop_tr[c+1] = o_drop;
            pend_tr[c+1] = o_pending;
            pend_or      = pend_or | o_pending;
        end
        i_pulse = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cmp_en = 0;
        rst_n = 1'b0; i_pulse = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_led",  64'(o_led),     64'd0);
        check("reset_busy", 64'(o_busy),    64'd0);
        check("reset_pend", 64'(o_pending), 64'd0);
        check("reset_drop", 64'(o_drop),    64'd0);
        rst_n = 1'b1;
        cmp_en = 1;
        @(negedge clk);

        // Single event
        run(64'h1, 12);
        check("single_led",  led_tr,  64'h1E);
        check("single_busy", busy_tr, 64'h7E);
        check("single_pend", 64'(pend_or), 64'd0);

        // Burst of three
        run(64'h7, 24);
        check("burst_led",    led_tr,  64'h1E79E);
        check("burst_busy",   busy_tr, 64'h7FFFE);
        check("burst_pend2",  64'(pend_tr[2]),  64'd1);
        check("burst_pend3",  64'(pend_tr[3]),  64'd2);
        check("burst_pend7",  64'(pend_tr[7]),  64'd1);
        check("burst_pend13", 64'(pend_tr[13]), 64'd0);

        // Overflow
        run(64'h3F, 30);
        check("ovf_led",   led_tr,  64'h79E79E);
        check("ovf_drop",  drop_tr, 64'h60);
        check("ovf_busy",  busy_tr, 64'h1FFFFFE);
        check("ovf_pend4", 64'(pend_tr[4]), 64'd3);

        // Pulse on last gap cycle with one event pending
        run(64'h43, 24);
        check("coin_led",   led_tr,  64'h1E79E);
        check("coin_pend7", 64'(pend_tr[7]), 64'd1);
        check("coin_drop",  drop_tr, 64'd0);

        // Pulse on last gap cycle with nothing pending
        run(64'h41, 18);
        check("gap0_led",  led_tr,  64'h79E);
        check("gap0_busy", busy_tr, 64'h1FFE);
        check("gap0_pend", 64'(pend_or), 64'd0);

        // Asynchronous reset mid-blink with two events queued
        run(64'h7, 3);
        check("rst_pre_pend", 64'(pend_tr[3]), 64'd2);
        check("rst_pre_led",  64'(led_tr[3]),  64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_led",  64'(o_led),     64'd0);
        check("rst_busy", 64'(o_busy),    64'd0);
        check("rst_pend", 64'(o_pending), 64'd0);
        check("rst_drop", 64'(o_drop),    64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(64'h0, 20);
        check("post_rst_led",  led_tr,  64'd0);
        check("post_rst_busy", busy_tr, 64'd0);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_event_flasher.md
Name: led_event_flasher

Overview:
- Converts single-cycle event strobes into human-visible LED blinks. It is the output-side counterpart of the key debouncer, which turns a slow physical level into a one-cycle pulse; this block turns one-cycle pulses back into slow physical levels.
- Sits between control logic (e.g. start/prev/next strobes) and LEDG/LEDR pins.
- Strobes that arrive while a blink is in progress are queued in a saturating counter and replayed as further blinks.

Parameters:
- ON_CNT, 12500000, cycles o_led is held high per blink (0.25 s at 50 MHz); must be >= 1.
- GAP_CNT, 12500000, cycles o_led is held low after each blink before the next one may start; must be >= 1.
- PEND_W, 4, width of the pending-event counter; it saturates at 2^PEND_W-1.

Ports:
- i_clk  input  1  system clock (CLOCK_50).
- i_rst_n  input  1  asynchronous active-low reset.
- i_pulse  input  1  event strobe; each cycle sampled high counts as one event.
- o_led  output  1  blink output, registered, active high.
- o_busy  output  1  high whenever the state is not IDLE.
- o_pending  output  PEND_W  queued events not yet blinked.
- o_drop  output  1  one-cycle pulse, registered; an event was lost because the queue was full.

Behaviour:
- Reset (async, active-low):
  - state=IDLE, o_led=0, o_busy=0, o_pending=0, o_drop=0, timer=0.
  - Reset asserted mid-blink forces o_led low immediately. All queued events are discarded.
- Timer:
  - Single down-counter, width $clog2(max(ON_CNT,GAP_CNT)+1).
- State machine (IDLE, ON, GAP):
  - IDLE, i_pulse=1 at edge k: go to ON, timer=ON_CNT-1. o_led is high in cycles k+1 .. k+ON_CNT, i.e. exactly ON_CNT cycles. Latency from strobe to o_led rising is 1 cycle.
  - ON: timer decrements each cycle. When timer==0: go to GAP, timer=GAP_CNT-1, o_led=0 next cycle.
  - GAP: timer decrements each cycle. When timer==0:
    - if pending>0 (after applying this cycle's i_pulse): go to ON, timer=ON_CNT-1, pending-1.
    - else: go to IDLE.
  - Blink period is therefore ON_CNT+GAP_CNT cycles. A new blink starts back-to-back with no extra idle cycle.
- Pending counter:
  - i_pulse=1 in ON or GAP: pending+1.
  - At saturation the increment is suppressed and o_drop=1 on the next cycle only.
  - Simultaneous increment and decrement (pulse on the last GAP cycle with pending>0): pending is unchanged, no drop.
  - Pulse on the last GAP cycle with pending=0: counts as pending+1 then -1. Result is pending=0 and the next blink starts; the event is not lost.
  - In IDLE, pending is always 0.
- o_busy = (state != IDLE), registered with the state.
- i_pulse held high for N cycles counts as N events. The upstream is expected to deliver single-cycle strobes (the debouncer's o_neg).

Test Plan:
(bench parameters: ON_CNT=4, GAP_CNT=2, PEND_W=2; cycle 0 = first edge sampling i_pulse=1)
- Single event: i_pulse high at cycle 0 only -> o_led=1 cycles 1-4, 0 cycles 5-6; o_busy=1 cycles 1-6, 0 from cycle 7; o_pending stays 0.
- Burst of 3: i_pulse high cycles 0,1,2 -> o_pending 1,2 after cycles 1,2; o_led high cycles 1-4, 7-10, 13-16; o_pending=1 at cycle 7, 0 at cycle 13; o_busy=0 from cycle 19.
- Overflow: i_pulse high cycles 0-5 -> pending saturates at 3 after cycle 3; o_drop=1 in cycles 5 and 6 only; exactly 4 blinks (o_led high 1-4, 7-10, 13-16, 19-22).
- Edge coincidence: one pending event, extra pulse on the last GAP cycle -> o_pending unchanged at 1, o_drop=0; the next blink starts immediately and one further blink follows.
- Reset mid-blink: assert i_rst_n=0 during cycle 2 of a blink with pending=2 -> o_led, o_busy, o_pending, o_drop all 0 asynchronously. After release with no pulses, o_led stays 0 indefinitely.
- Pulse on last GAP cycle with pending=0 -> new blink begins the next cycle; o_pending stays 0; o_busy never drops.
